// File: rtl/io_reg_bank_if.sv
// io_reg_bank_if: data-memory bus to the I/O register bank.
// The master drives the write strobe, byte enables, word address and data.
// The slave returns read data combinationally from the address.
interface io_reg_bank_if;
  logic        i_wren;
  logic [3:0]  i_bmask;
  logic [3:0]  i_address;
  logic [31:0] i_data;
  logic [31:0] o_data;

  modport master (
    output i_wren, i_bmask, i_address, i_data,
    input  o_data
  );

  modport slave (
    input  i_wren, i_bmask, i_address, i_data,
    output o_data
  );
endinterface

// File: rtl/io_reg_bank.sv
// io_reg_bank: memory-mapped I/O page containing:
//   - byte-writable output registers,
//   - synchronised switches,
//   - buttons, a sticky press-capture register (write-1-to-clear),
//   - a free-running tick counter.
// Optional feature macro IO_DEBOUNCE_EN:
//   defined   -> each button runs through a counter debouncer;
//   undefined -> the debounced value is the synchroniser output.
// Reads are combinational from the address.
module io_reg_bank #(
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned SW_W       = 32,
  parameter int unsigned BTN_W      = 4,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  io_reg_bank_if.slave            bus,
  input  logic [SW_W-1:0]         i_io_sw,
  input  logic [BTN_W-1:0]        i_io_btn,
  output logic [NUM_OUT*32-1:0]   o_out
);

  localparam logic [3:0] ADDR_SW   = 4'h8;
  localparam logic [3:0] ADDR_BTN  = 4'h9;
  localparam logic [3:0] ADDR_CAP  = 4'hA;
  localparam logic [3:0] ADDR_TICK = 4'hB;

  if (NUM_OUT < 1 || NUM_OUT > 8 || SW_W < 1 || SW_W > 32 ||
      BTN_W < 1 || BTN_W > 32 || DEB_CYCLES < 1) begin : g_bad_param
    $error("io_reg_bank: parameter out of range");
  end

  logic [31:0]      out_q [NUM_OUT];
  logic [31:0]      out_d [NUM_OUT];
  logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q;
  logic [BTN_W-1:0] db_q, db_d;
  logic [BTN_W-1:0] cap_q, cap_d, cap_clr;
  logic [31:0]      tick_q;
  logic [31:0]      rdata;

  // Byte-masked update of the addressed output register.
  always_comb begin
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      out_d[k] = out_q[k];
      if (bus.i_wren && bus.i_address == 4'(k)) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (bus.i_bmask[b]) out_d[k][8*b +: 8] = bus.i_data[8*b +: 8];
        end
      end
    end
  end

  // Output register state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
    end
  end

  // Flatten output registers onto the o_out bus.
  always_comb begin
    o_out = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) o_out[32*k +: 32] = out_q[k];
  end

  // Two-stage synchronisers for switches and buttons, plus the tick counter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      tick_q   <= '0;
    end else begin
      sw_s1_q  <= i_io_sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= i_io_btn;
      btn_s2_q <= btn_s1_q;
      tick_q   <= tick_q + 32'd1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q [BTN_W];
  logic [CW-1:0] cnt_d [BTN_W];

  // Per-bit debouncer: any agreement restarts the count; the bit toggles
  // after DEB_CYCLES consecutive mismatching edges.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < BTN_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
        db_d[i]  = ~db_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debouncer state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      db_q <= '0;
      for (int unsigned i = 0; i < BTN_W; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int unsigned i = 0; i < BTN_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  // Without debouncing the second synchroniser stage is the debounced bit;
  // its next value is the first stage, which feeds rising-edge capture.
  assign db_q = btn_s2_q;
  assign db_d = btn_s1_q;
`endif

  // Capture next state: write-1-to-clear, with a rising edge of db taking priority.
  always_comb begin
    cap_clr = '0;
    if (bus.i_wren && bus.i_address == ADDR_CAP) begin
      for (int unsigned i = 0; i < BTN_W; i++) begin
        cap_clr[i] = bus.i_bmask[i/8] & bus.i_data[i];
      end
    end
    cap_d = (cap_q & ~cap_clr) | (db_d & ~db_q);
  end

  // Capture register state.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) cap_q <= '0;
    else        cap_q <= cap_d;
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    rdata = '0;
    case (bus.i_address)
      ADDR_SW:   rdata = 32'(sw_s2_q);
      ADDR_BTN:  rdata = 32'(db_q);
      ADDR_CAP:  rdata = 32'(cap_q);
      ADDR_TICK: rdata = tick_q;
      default: begin
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
          if (bus.i_address == 4'(k)) rdata = out_q[k];
        end
      end
    endcase
  end

  assign bus.o_data = rdata;

endmodule

// File: tb/tb_io_reg_bank.sv
// tb_io_reg_bank: self-checking bench for io_reg_bank.
// Directed scenarios plus randomized traffic, all compared against a
// behavioural model of the register page.
module tb_io_reg_bank;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned SW_W    = 16;
  localparam int unsigned BTN_W   = 4;
  localparam int unsigned DEB     = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int unsigned PRESS_LAT = DEB + 2;
`else
  localparam int unsigned PRESS_LAT = 2;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [SW_W-1:0]        sw = '0;
  logic [BTN_W-1:0]       btn = '0;
  logic [NUM_OUT*32-1:0]  out;
  int                     errors = 0;
  int                     checks = 0;

  io_reg_bank_if bus ();

  io_reg_bank #(
    .NUM_OUT    (NUM_OUT),
    .SW_W       (SW_W),
    .BTN_W      (BTN_W),
    .DEB_CYCLES (DEB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .bus      (bus),
    .i_io_sw  (sw),
    .i_io_btn (btn),
    .o_out    (out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [31:0]      m_out [NUM_OUT];
  logic [SW_W-1:0]  m_sw_seen, m_sw_vis;
  logic [BTN_W-1:0] m_btn_seen, m_btn_sync, m_db, m_cap, m_db_old;
  int unsigned      m_run [BTN_W];
  logic [31:0]      m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OUT; k++) m_out[k] = 0;
      for (int i = 0; i < BTN_W; i++) m_run[i] = 0;
      m_sw_seen = 0; m_sw_vis = 0; m_btn_seen = 0; m_btn_sync = 0;
      m_db = 0; m_cap = 0; m_tick = 0;
    end else begin
      if (bus.i_wren && bus.i_address < NUM_OUT)
        for (int b = 0; b < 4; b++)
          if (bus.i_bmask[b]) m_out[bus.i_address[1:0]][8*b +: 8] = bus.i_data[8*b +: 8];
      m_db_old = m_db;
`ifdef IO_DEBOUNCE_EN
      // db flips once the synchronised button has disagreed for DEB edges in a row
      for (int i = 0; i < BTN_W; i++) begin
        if (m_btn_sync[i] == m_db[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin m_db[i] = ~m_db[i]; m_run[i] = 0; end
        end
      end
`else
      m_db = m_btn_seen;
`endif
      if (bus.i_wren && bus.i_address == 4'hA)
        for (int i = 0; i < BTN_W; i++)
          if (bus.i_bmask[i/8] && bus.i_data[i]) m_cap[i] = 1'b0;
      m_cap = m_cap | (m_db & ~m_db_old);
      m_sw_vis   = m_sw_seen;
      m_sw_seen  = sw;
      m_btn_sync = m_btn_seen;
      m_btn_seen = btn;
      m_tick     = m_tick + 1;
    end
  end

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = 0;
    case (a)
      4'h8: r = 32'(m_sw_vis);
      4'h9: r = 32'(m_db);
      4'hA: r = 32'(m_cap);
      4'hB: r = m_tick;
      default: if (a < NUM_OUT) r = m_out[a[1:0]];
    endcase
    return r;
  endfunction

  function automatic logic [NUM_OUT*32-1:0] m_flat();
    logic [NUM_OUT*32-1:0] f;
    for (int k = 0; k < NUM_OUT; k++) f[32*k +: 32] = m_out[k];
    return f;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.i_address = a; bus.i_data = d; bus.i_bmask = m; bus.i_wren = 1'b1;
    edge1();
    bus.i_wren = 1'b0; bus.i_bmask = 4'h0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] got;
    bus.i_wren = 0; bus.i_bmask = 0; bus.i_address = 0; bus.i_data = 0;
    sw = 0; btn = 0; rst_n = 0;
    #1;
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
    for (int a = 0; a < 16; a++) begin
      bus.i_address = 4'(a);
      #1;
      got = bus.o_data;
      checks++;
      if (got !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got %h expected 0", a, got); end
    end
    @(negedge clk);
    rst_n = 1;
    edge1();
  endtask

  task automatic test_byte_mask();
    bus_write(4'h1, 32'hAABBCCDD, 4'hF);
    bus.i_address = 4'h1; bus.i_data = 32'h11223344; bus.i_bmask = 4'h5; bus.i_wren = 1;
    #1;
    checks++;
    if (bus.o_data !== 32'hAABBCCDD) begin errors++; $display("FAIL same_cycle_read: got %h expected aabbccdd", bus.o_data); end
    edge1();
    bus.i_wren = 0; bus.i_bmask = 0;
    #1;
    checks++;
    if (bus.o_data !== 32'hAA22CC44) begin errors++; $display("FAIL byte_mask_read: got %h expected aa22cc44", bus.o_data); end
    checks++;
    if (out[63:32] !== 32'hAA22CC44) begin errors++; $display("FAIL byte_mask_out: got %h expected aa22cc44", out[63:32]); end
    bus_write(4'h1, 32'hFFFFFFFF, 4'h0);
    checks++;
    if (bus.o_data !== 32'hAA22CC44) begin errors++; $display("FAIL zero_mask_noop: got %h expected aa22cc44", bus.o_data); end
  endtask

  task automatic test_unmapped();
    bus_write(4'h6, 32'h12345678, 4'hF);
    #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL unmapped_6: got %h expected 0", bus.o_data); end
    bus_write(4'hC, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL unmapped_c: got %h expected 0", bus.o_data); end
    bus_write(4'h8, 32'hFFFFFFFF, 4'hF);
    #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL ro_switch_write: got %h expected 0", bus.o_data); end
    checks++;
    if (out !== m_flat()) begin errors++; $display("FAIL unmapped_out: got %h expected %h", out, m_flat()); end
  endtask

  task automatic test_async_reset();
    bus_write(4'h0, 32'hCAFEF00D, 4'hF);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out !== '0) begin errors++; $display("FAIL async_reset_out: got %h expected 0", out); end
    bus.i_address = 4'hB;
    #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL async_reset_tick: got %h expected 0", bus.o_data); end
    @(negedge clk);
    rst_n = 1;
    edge1();
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL tick_after_release: got %h expected 1", bus.o_data); end
    edge1();
    checks++;
    if (bus.o_data !== 32'h2) begin errors++; $display("FAIL tick_second_edge: got %h expected 2", bus.o_data); end
  endtask

  task automatic test_switch_sync();
    bus.i_address = 4'h8;
    sw = 16'h5A5A;
    edge1();
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL sw_sync_stage1: got %h expected 0", bus.o_data); end
    edge1();
    checks++;
    if (bus.o_data !== 32'h5A5A) begin errors++; $display("FAIL sw_sync_stage2: got %h expected 5a5a", bus.o_data); end
    checks++;
    if (bus.o_data !== m_read(4'h8)) begin errors++; $display("FAIL sw_model: got %h expected %h", bus.o_data, m_read(4'h8)); end
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_bounce();
    btn = 4'h1;
    repeat (3) edge1();
    btn = 4'h0;
    repeat (8) edge1();
    bus.i_address = 4'h9; #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL bounce_db: got %h expected 0", bus.o_data); end
    bus.i_address = 4'hA; #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL bounce_cap: got %h expected 0", bus.o_data); end
    bus.i_address = 4'h9;
    btn = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      checks++;
      if (bus.o_data !== ((k >= int'(DEB) + 2) ? 32'h1 : 32'h0)) begin
        errors++;
        $display("FAIL held_db edge %0d: got %h expected %h", k, bus.o_data, (k >= int'(DEB) + 2) ? 32'h1 : 32'h0);
      end
    end
    bus.i_address = 4'hA; #1;
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL held_cap: got %h expected 1", bus.o_data); end
  endtask
`else
  task automatic test_pulse();
    bus.i_address = 4'h9;
    btn = 4'h1;
    edge1();
    btn = 4'h0;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL pulse_edge1: got %h expected 0", bus.o_data); end
    edge1();
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL pulse_edge2: got %h expected 1", bus.o_data); end
    edge1();
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL pulse_edge3: got %h expected 0", bus.o_data); end
    bus.i_address = 4'hA; #1;
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL pulse_cap: got %h expected 1", bus.o_data); end
  endtask
`endif

  task automatic test_capture_clear();
    bus.i_address = 4'hA; #1;
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL cap_before_clear: got %h expected 1", bus.o_data); end
    bus_write(4'hA, 32'h1, 4'hF);
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL cap_cleared: got %h expected 0", bus.o_data); end
    btn = 4'h0;
    repeat (PRESS_LAT + 3) edge1();
    bus.i_address = 4'h9; #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL released_db: got %h expected 0", bus.o_data); end
    btn = 4'h1;
    repeat (PRESS_LAT - 1) edge1();
    bus.i_address = 4'hA; #1;
    checks++;
    if (bus.o_data !== 32'h0) begin errors++; $display("FAIL cap_pre_collide: got %h expected 0", bus.o_data); end
    bus_write(4'hA, 32'h1, 4'h1);
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL set_beats_clear: got %h expected 1", bus.o_data); end
    bus.i_address = 4'h9; #1;
    checks++;
    if (bus.o_data !== 32'h1) begin errors++; $display("FAIL collide_db: got %h expected 1", bus.o_data); end
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [31:0] exp_r;
    for (int n = 0; n < 400; n++) begin
      a = 4'($urandom_range(0, 15));
      bus.i_address = a;
      bus.i_wren    = ($urandom_range(0, 1) == 1);
      bus.i_bmask   = 4'($urandom);
      bus.i_data    = $urandom;
      if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
      for (int i = 0; i < BTN_W; i++)
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      #1;
      exp_r = m_read(a);
      checks++;
      if (bus.o_data !== exp_r) begin errors++; $display("FAIL rand_read[%0d] addr %h: got %h expected %h", n, a, bus.o_data, exp_r); end
      checks++;
      if (out !== m_flat()) begin errors++; $display("FAIL rand_out[%0d]: got %h expected %h", n, out, m_flat()); end
      edge1();
    end
    bus.i_wren = 0;
    bus.i_bmask = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_mask();
    test_unmapped();
    test_async_reset();
    test_switch_sync();
`ifdef IO_DEBOUNCE_EN
    test_bounce();
`else
    test_pulse();
`endif
    test_capture_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
